// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers active-pixel x/y from VGA sync/DE samples,
// measures line and frame periods, and declares lock after stable frames.
module vga_timing_monitor #(
   parameter int H_ACTIVE    = 640,
   parameter int H_TOTAL     = 800,
   parameter int V_ACTIVE    = 480,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pclk,
   input  logic       h_sync,
   input  logic       v_sync,
   input  logic       DE,
   output logic       pix_valid,
   output logic [9:0] x_pixel,
   output logic [9:0] y_pixel,
   output logic       line_start,
   output logic       frame_start,
   output logic [9:0] h_total,
   output logic [9:0] v_total,
   output logic       locked,
   output logic       timing_err
);
   localparam logic [9:0] MAX = 10'd1023;

   typedef enum logic [1:0] {SEARCH, CHECK, LOCK} state_t;

   state_t     state, state_nx;
   logic [2:0] good, good_nx;
   logic       h_q, v_q, de_q, frame_bad;
   logic [9:0] h_cnt, v_cnt, x_cnt, y_cnt, de_run;
   logic [9:0] v_lines, y_lines;
   logic       h_edge, v_edge, de_fall, line_ok, frame_ok, err;

   // v_lines/y_lines include this tick's line and DE line, so a frame closed
   // on the same tick as a line sees that line counted.
   always_comb begin
      h_edge   = h_q & ~h_sync;
      v_edge   = v_q & ~v_sync;
      de_fall  = de_q & ~DE;
      v_lines  = (h_edge && v_cnt != MAX) ? v_cnt + 10'd1 : v_cnt;
      y_lines  = (de_fall && y_cnt != MAX) ? y_cnt + 10'd1 : y_cnt;
      line_ok  = h_cnt != MAX && h_cnt == 10'(H_TOTAL - 1) && de_run != MAX &&
                 (de_run == 10'(H_ACTIVE) || de_run == '0);
      frame_ok = v_lines != MAX && v_lines == 10'(V_TOTAL) && y_lines != MAX &&
                 y_lines == 10'(V_ACTIVE) && !frame_bad && !(h_edge && !line_ok);
   end

   always_comb begin
      state_nx = state;
      good_nx  = good;
      err      = 1'b0;
      if (pclk) begin
         case (state)
            SEARCH: state_nx = v_edge ? CHECK : SEARCH;
            CHECK: if (v_edge) begin
               good_nx  = frame_ok ? good + 3'd1 : '0;
               state_nx = (frame_ok && good + 3'd1 == 3'(LOCK_FRAMES)) ? LOCK : CHECK;
            end
            default: if ((h_edge && !line_ok) || (v_edge && !frame_ok)) begin
               err      = 1'b1;
               state_nx = CHECK;
               good_nx  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= SEARCH;
         good        <= '0;
         h_q         <= 1'b1;
         v_q         <= 1'b1;
         de_q        <= 1'b0;
         frame_bad   <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         x_cnt       <= '0;
         y_cnt       <= '0;
         de_run      <= '0;
         pix_valid   <= 1'b0;
         x_pixel     <= '0;
         y_pixel     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         h_total     <= '0;
         v_total     <= '0;
         locked      <= 1'b0;
         timing_err  <= 1'b0;
      end else begin
         state       <= state_nx;
         good        <= good_nx;
         pix_valid   <= pclk & DE;
         line_start  <= pclk & h_edge;
         frame_start <= pclk & v_edge;
         timing_err  <= err;
         locked      <= state_nx == LOCK;
         if (pclk) begin
            h_q       <= h_sync;
            v_q       <= v_sync;
            de_q      <= DE;
            h_cnt     <= h_edge ? '0 : (h_cnt == MAX ? MAX : h_cnt + 10'd1);
            de_run    <= h_edge ? {9'd0, DE} : ((DE && de_run != MAX) ? de_run + 10'd1 : de_run);
            v_cnt     <= v_edge ? '0 : v_lines;
            y_cnt     <= v_edge ? '0 : y_lines;
            x_cnt     <= de_fall ? '0 : (DE ? x_cnt + 10'd1 : x_cnt);
            frame_bad <= v_edge ? 1'b0 : frame_bad | (h_edge & ~line_ok);
            if (h_edge) h_total <= h_cnt == MAX ? MAX : h_cnt + 10'd1;
            if (v_edge) v_total <= v_lines;
            if (DE) begin
               x_pixel <= x_cnt;
               y_pixel <= y_cnt;
            end
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: small-raster stream generator, timestamp-based
// reference model compared every clock, plus hand-computed scenario checks.
module tb_vga_timing_monitor;
   localparam int HA = 8, HT = 12, VA = 4, VT = 6, LF = 2;

   logic clk = 0, reset = 0, pclk = 0, h_sync = 1, v_sync = 1, DE = 0;
   logic pix_valid, line_start, frame_start, locked, timing_err;
   logic [9:0] x_pixel, y_pixel, h_total, v_total;
   int checks = 0, failures = 0;

   vga_timing_monitor #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(LF)) dut (
      .clk(clk), .reset(reset), .pclk(pclk), .h_sync(h_sync), .v_sync(v_sync), .DE(DE),
      .pix_valid(pix_valid), .x_pixel(x_pixel), .y_pixel(y_pixel), .line_start(line_start),
      .frame_start(frame_start), .h_total(h_total), .v_total(v_total), .locked(locked),
      .timing_err(timing_err));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: line/frame lengths from tick timestamps and event counts.
   int  t, last_h, de_line, lines, m_falls, m_x, good;
   bit  ph, pv, pde, fbad, searching, lk, started;
   logic       exp_pv, exp_ls, exp_fs, exp_te, exp_lk;
   logic [9:0] exp_x, exp_y, exp_ht, exp_vt;

   always @(posedge clk) begin : model
      int len;
      bit he, ve, df, lok, fok;
      exp_pv = 0; exp_ls = 0; exp_fs = 0; exp_te = 0;
      if (!reset) begin
         t = 0; last_h = 0; de_line = 0; lines = 0; m_falls = 0; m_x = 0; good = 0;
         ph = 1; pv = 1; pde = 0; fbad = 0; searching = 1; lk = 0;
         exp_x = 0; exp_y = 0; exp_ht = 0; exp_vt = 0;
      end else if (pclk) begin
         t++;
         he = ph && !h_sync;
         ve = pv && !v_sync;
         df = pde && !DE;
         if (DE) begin exp_pv = 1; exp_x = 10'(m_x); exp_y = 10'(m_falls); end
         if (he) begin
            len = t - last_h;
            lok = len == HT && (de_line == HA || de_line == 0);
            exp_ls = 1;
            exp_ht = len > 1023 ? 10'd1023 : 10'(len);
            if (!lok) fbad = 1;
            if (lk && !lok) begin exp_te = 1; lk = 0; good = 0; end
            last_h = t; de_line = 0; lines++;
         end
         if (DE) de_line++;
         if (df) begin m_falls++; m_x = 0; end
         else if (DE) m_x++;
         if (ve) begin
            exp_fs = 1;
            exp_vt = lines > 1023 ? 10'd1023 : 10'(lines);
            fok = lines == VT && m_falls == VA && !fbad;
            if (searching) searching = 0;
            else if (lk) begin
               if (!fok) begin exp_te = 1; lk = 0; good = 0; end
            end else if (fok) begin
               good++;
               if (good == LF) lk = 1;
            end else good = 0;
            fbad = 0; lines = 0; m_falls = 0;
         end
         ph = h_sync; pv = v_sync; pde = DE;
      end
      exp_lk = lk;
      started = 1;
   end

   always @(negedge clk) if (started) begin
      checks++;
      if ({pix_valid, x_pixel, y_pixel, line_start, frame_start, h_total, v_total, locked, timing_err} !==
          {exp_pv, exp_x, exp_y, exp_ls, exp_fs, exp_ht, exp_vt, exp_lk, exp_te}) begin
         failures++;
         $display("FAIL model_cmp at %0t: got pv=%b x=%0d y=%0d ls=%b fs=%b ht=%0d vt=%0d lk=%b te=%b expected pv=%b x=%0d y=%0d ls=%b fs=%b ht=%0d vt=%0d lk=%b te=%b",
                  $time, pix_valid, x_pixel, y_pixel, line_start, frame_start, h_total, v_total, locked, timing_err,
                  exp_pv, exp_x, exp_y, exp_ls, exp_fs, exp_ht, exp_vt, exp_lk, exp_te);
      end
   end

   // Scenario statistics taken from the DUT outputs.
   int fs_cnt = 0, pv_cnt = 0, frame_pix = 0, ls_cnt = 0, te_cnt = 0, lock_at = -1, te_fs = -1, x_max = 0;
   int first_x, first_y, last_x, last_y, f_first_x, f_first_y, f_last_x, f_last_y;
   bit locked_q = 0, lock_seen = 0;

   always @(negedge clk) begin
      if (frame_start) begin
         fs_cnt++;
         frame_pix = pv_cnt; pv_cnt = 0;
         f_first_x = first_x; f_first_y = first_y; f_last_x = last_x; f_last_y = last_y;
      end
      if (pix_valid) begin
         if (pv_cnt == 0) begin first_x = x_pixel; first_y = y_pixel; end
         last_x = x_pixel; last_y = y_pixel;
         if (int'(x_pixel) > x_max) x_max = x_pixel;
         pv_cnt++;
      end
      ls_cnt += int'(line_start);
      if (timing_err) begin te_cnt++; te_fs = fs_cnt; end
      if (locked && !locked_q) lock_at = fs_cnt;
      if (locked) lock_seen = 1;
      locked_q = locked;
   end

   // Generator: h_sync low ticks 0-1, DE ticks 3..3+de_w-1 on lines 1..VA, v_sync low on line 0.
   int hx = 5, vy = 3, de_w = HA;
   bit stretch = 0, hold_h = 0, te_arm = 0;

   task automatic tick();
      int len;
      bit closing;
      @(negedge clk);
      pclk = 1;
      h_sync = hold_h || hx >= 2;
      v_sync = vy != 0;
      DE = hx >= 3 && hx < 3 + de_w && vy >= 1 && vy <= VA;
      closing = te_arm && hx == 0;
      len = (stretch && vy == 2) ? HT + 1 : HT;
      hx++;
      if (hx == len) begin
         hx = 0;
         if (stretch && vy == 2) begin stretch = 0; te_arm = 1; end
         vy = (vy + 1) % VT;
      end
      @(negedge clk);
      pclk = 0;
      if (closing) begin
         chk("timing_err_after_long_line", timing_err, 1);
         chk("locked_drop_same_cycle", locked, 0);
         te_arm = 0;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [44:0] snap;
      // Nominal stream, reset released mid-frame.
      repeat (3) tick();
      chk("reset_locked", locked, 0);
      chk("reset_h_total", h_total, 0);
      chk("reset_pix_valid", pix_valid, 0);
      @(negedge clk);
      reset = 1;
      fs_cnt = 0; lock_at = -1;
      repeat (3 * HT * VT + 10) tick();
      chk("lock_at_third_vsync", lock_at, 3);
      chk("locked_nominal", locked, 1);
      chk("h_total_nominal", h_total, 12);
      chk("v_total_nominal", v_total, 6);
      repeat (HT * VT) tick();
      chk("pixels_per_frame", frame_pix, 32);
      chk("first_x", f_first_x, 0);
      chk("first_y", f_first_y, 0);
      chk("last_x", f_last_x, 7);
      chk("last_y", f_last_y, 3);

      // One line stretched by a tick while locked.
      stretch = 1; te_cnt = 0; fs_cnt = 0; lock_at = -1;
      repeat (5 * HT * VT) tick();
      chk("stretch_err_count", te_cnt, 1);
      chk("relock_after_two_clean", lock_at - te_fs, 3);
      chk("relocked", locked, 1);

      // pclk idle with toggling inputs: nothing may move.
      snap = {pix_valid, x_pixel, y_pixel, line_start, frame_start, h_total, v_total, locked, timing_err};
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         h_sync = ~h_sync; v_sync = i[2]; DE = ~DE;
         chk("pclk_idle_hold", {pix_valid, x_pixel, y_pixel, line_start, frame_start, h_total, v_total, locked, timing_err}, snap);
      end
      te_cnt = 0;
      repeat (2 * HT * VT) tick();
      chk("idle_resume_locked", locked, 1);
      chk("idle_resume_no_err", te_cnt, 0);

      // h_sync stuck high: counter saturates, no line_start, lock lost.
      hold_h = 1; ls_cnt = 0; te_cnt = 0;
      repeat (3000) tick();
      chk("stuck_h_no_line_start", ls_cnt, 0);
      chk("stuck_h_unlocked", locked, 0);
      chk("stuck_h_err_once", te_cnt, 1);
      hold_h = 0;
      repeat (HT) tick();
      chk("stuck_h_release_line_start", ls_cnt, 1);

      // Reset on a tick carrying an h_sync edge: reset wins.
      while (hx != 0) tick();
      @(negedge clk);
      reset = 0; pclk = 1; h_sync = 0; v_sync = 1; DE = 0;
      @(negedge clk);
      pclk = 0;
      chk("reset_wins_line_start", line_start, 0);
      chk("reset_wins_h_total", h_total, 0);
      chk("reset_wins_v_total", v_total, 0);
      chk("reset_wins_locked", locked, 0);
      @(negedge clk);
      hx = 5; vy = 2;
      h_sync = 1;
      @(negedge clk);
      reset = 1; ls_cnt = 0; fs_cnt = 0; lock_at = -1;
      repeat (6) tick();
      chk("release_no_line_start", ls_cnt, 0);
      repeat (HT) tick();
      chk("release_first_real_edge", ls_cnt, 1);
      repeat (3 * HT * VT) tick();
      chk("relock_after_reset", locked, 1);

      // DE one pixel short on every line: never locks.
      @(negedge clk); reset = 0;
      @(negedge clk); reset = 1;
      de_w = HA - 1; lock_seen = 0; x_max = 0;
      repeat (5 * HT * VT) tick();
      chk("short_de_never_locks", lock_seen, 0);
      chk("short_de_x_max", x_max, 6);
      chk("short_de_pixels", frame_pix, 28);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
